// File: rtl/kyber_tomont_pipe_if.sv
// kyber_tomont_pipe_if: valid/ready stream bundle for the to-Montgomery pipe.
// slave = the pipe, master = the producer/consumer around it.
interface kyber_tomont_pipe_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_r;
  logic               out_last;

  modport slave (
    input  in_valid,
    input  in_a,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_r,
    output out_last
  );

  modport master (
    output in_valid,
    output in_a,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_r,
    input  out_last
  );
endinterface

// File: rtl/kyber_tomont_pipe.sv
// kyber_tomont_pipe: a -> a*2^16 mod q via Montgomery reduction of a*MONT2.
// Optional TOMONT_FREEZE_EN adds a 4th stage mapping the result into [0, q-1].
module kyber_tomont_pipe #(
  parameter int KYBER_Q = 3329,
  parameter int QINV    = -3327,
  parameter int MONT2   = 1353,
  parameter int NCOEF   = 256
) (
  input  logic clk,
  input  logic rst_n,
  kyber_tomont_pipe_if.slave bus
);

  localparam int CW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCOEF - 1);

  logic               stall;
  logic               en;
  logic               vo;
  logic signed [15:0] ro;
  logic               xfer;

  logic               v1;
  logic               v2;
  logic               v3;
  logic signed [31:0] p1;
  logic signed [31:0] p2;
  logic signed [15:0] u2;
  logic signed [15:0] r3;

  logic signed [31:0] p_nx;
  logic signed [15:0] u_nx;
  logic signed [15:0] r_nx;

  logic [CW-1:0]      cnt;

  assign p_nx = 32'(bus.in_a * MONT2);
  assign u_nx = 16'($signed(p1[15:0]) * QINV);
  assign r_nx = 16'((p2 - u2 * KYBER_Q) >>> 16);

  assign stall = vo && !bus.out_ready;
  assign en    = !stall;
  assign xfer  = vo && bus.out_ready;

  assign bus.in_ready  = en;
  assign bus.out_valid = vo;
  assign bus.out_r     = ro;
  assign bus.out_last  = vo && (cnt == LAST_IDX);

  // Three reduction stages advancing together whenever the output is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      p1 <= '0;
      p2 <= '0;
      u2 <= '0;
      r3 <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
      p1 <= p_nx;
      p2 <= p1;
      u2 <= u_nx;
      r3 <= r_nx;
    end
  end

`ifdef TOMONT_FREEZE_EN
  logic               v4;
  logic signed [15:0] r4;

  // Freeze stage: fold a negative reduced value up by one modulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4 <= 1'b0;
      r4 <= '0;
    end else if (en) begin
      v4 <= v3;
      r4 <= (r3 < 0) ? 16'(r3 + KYBER_Q) : r3;
    end
  end

  assign vo = v4;
  assign ro = r4;
`else
  assign vo = v3;
  assign ro = r3;
`endif

  // Coefficient index of the word currently on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_kyber_tomont_pipe.sv
// tb_kyber_tomont_pipe: scoreboard bench for the to-Montgomery pipe.
// Honours TOMONT_FREEZE_EN for latency and output range.
module tb_kyber_tomont_pipe;

  localparam int Q = 3329;
`ifdef TOMONT_FREEZE_EN
  localparam int LAT = 4;
  localparam int LO  = 0;
  localparam int E0  = 2285;
`else
  localparam int LAT = 3;
  localparam int LO  = -(Q - 1);
  localparam int E0  = -1044;
`endif

  typedef struct {
    int a;
    bit exact;
    int val;
    bit last;
    bit chk_lat;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kyber_tomont_pipe_if bus();

  kyber_tomont_pipe dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   checks = 0;
  int   errs   = 0;
  int   cyc    = 0;
  int   idx    = 0;
  bit   rand_rdy = 1'b0;
  exp_t sbq[$];

  bit             prev_stall = 1'b0;
  logic [15:0]    prev_r;
  logic           prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = 1'($urandom % 2);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit val_ok(input exp_t e, input int r);
    longint d;
    if (e.exact) return r == e.val;
    d = longint'(r) - longint'(e.a) * 65536;
    return (d % Q == 0) && (r >= LO) && (r <= Q - 1);
  endfunction

  // Monitor: pops the scoreboard on each output transfer and watches stalls.
  always @(negedge clk) begin
    exp_t e;
    int r;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.out_valid && bus.out_r == prev_r &&
              bus.out_last == prev_last)) begin
          errs++;
          $display("FAIL stall_hold: got v=%0b r=%0d l=%0b, expected r=%0d l=%0b",
                   bus.out_valid, $signed(bus.out_r), bus.out_last,
                   $signed(prev_r), prev_last);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_out: got r=%0d, expected no output",
                   $signed(bus.out_r));
        end else begin
          e = sbq.pop_front();
          r = int'($signed(bus.out_r));
          checks++;
          if (!val_ok(e, r)) begin
            errs++;
            $display("FAIL out_r: in_a=%0d got %0d, expected %0d (exact=%0b)",
                     e.a, r, e.val, e.exact);
          end
          chk("out_last", int'(bus.out_last), int'(e.last));
          if (e.chk_lat) chk("latency", cyc - e.cyc, LAT);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_r     = bus.out_r;
      prev_last  = bus.out_last;
    end
  end

  // Present one coefficient; returns at posedge+1 after it was accepted.
  task automatic send(input int a, input bit ex, input int v, input bit cl);
    exp_t e;
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'(a);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 1000 cycles");
      $fatal(1, "input stuck");
    end
    e.a       = a;
    e.exact   = ex;
    e.val     = v;
    e.last    = (idx == 255);
    e.chk_lat = cl;
    e.cyc     = cyc;
    idx       = (idx + 1) % 256;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2000 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_left", sbq.size(), 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_r", int'($signed(bus.out_r)), 0);
    sbq.delete();
    idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("init_out_valid", int'(bus.out_valid), 0);
    chk("init_in_ready", int'(bus.in_ready), 1);
    chk("init_out_last", int'(bus.out_last), 0);
    chk("init_out_r", int'($signed(bus.out_r)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(1, 1'b1, E0, 1'b1);
    send(0, 1'b1, 0, 1'b1);
    send(-1, 1'b1, 1044, 1'b1);
    send(3328, 1'b1, 1044, 1'b1);
    drain();

    do_reset();
    for (int i = 0; i < 256; i++) send(i, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) send(-i - 7, 1'b0, 0, 1'b1);
    drain();

    for (int i = 0; i < 6; i++) send(1000 * i - 2500, 1'b0, 0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom % 2 == 1) send(int'($signed(16'($urandom))), 1'b0, 0, 1'b0);
      else idle(1);
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 100; i++) send(3 * i - 150, 1'b0, 0, 1'b1);
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    do_reset();
    for (int i = 0; i < 259; i++) send(31 * i - 4000, 1'b0, 0, 1'b1);
    drain();

    for (int a = -32768; a <= 32767; a++) send(a, 1'b0, 0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/kyber_tomont_pipe.md
KYBER_TOMONT_PIPE -- requirements
Module: kyber_tomont_pipe

Interface
REQ-001 SHALL declare parameter KYBER_Q, default 3329, modulus q.
REQ-002 SHALL declare parameter QINV, default -3327, q^-1 mod 2^16, signed.
REQ-003 SHALL declare parameter MONT2, default 1353, 2^32 mod q.
REQ-004 SHALL declare parameter NCOEF, default 256, coefficients per polynomial.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  in_a holds a coefficient.
REQ-008 in_ready  output  1  block accepts in_a this cycle.
REQ-009 in_a  input  16  signed int16 coefficient, normal domain.
REQ-010 out_valid  output  1  out_r holds a result.
REQ-011 out_ready  input  1  consumer accepts out_r this cycle.
REQ-012 out_r  output  16  signed int16 coefficient, Montgomery domain.
REQ-013 out_last  output  1  out_r is coefficient NCOEF-1 of a polynomial.

Function
REQ-014 SHALL compute out_r congruent to in_a*2^16 mod q, i.e. Montgomery-reduce(in_a*MONT2).
REQ-015 Stage 1 SHALL register p = in_a*MONT2 as a signed 32-bit product.
REQ-016 Stage 2 SHALL register p and u = low16(p)*QINV truncated to signed int16.
REQ-017 Stage 3 SHALL register (p - u*KYBER_Q) arithmetic-shifted right 16, truncated to int16; the subtraction is 32-bit signed, and the low 16 bits are zero by construction.
REQ-018 Without freeze, out_r SHALL lie in [-(q-1), q-1].
REQ-019 Handshake: a transfer occurs on a cycle where valid and ready are both high; each accepted input produces exactly one output, in order.
REQ-020 Latency SHALL be 3 cycles from input transfer to out_valid while out_ready stays high; throughput one per cycle.
REQ-021 Stall = out_valid and !out_ready; during stall all stage registers, valids and the counter SHALL hold.
REQ-022 in_ready SHALL equal !stall (combinational from out_ready); no input is lost or duplicated under any valid/ready pattern.
REQ-023 Bubbles (in_valid low) SHALL propagate as cleared stage valids; out_r is don't-care when out_valid is low.
REQ-024 An output counter of ceil(log2 NCOEF) bits SHALL increment on each output transfer and wrap from NCOEF-1 to 0.
REQ-025 out_last SHALL be high exactly when out_valid is high and the counter equals NCOEF-1.
REQ-026 out_valid, out_r and out_last SHALL remain stable while stalled.

Reset
REQ-027 On rst_n low, all stage valids, out_valid, out_last and the counter SHALL clear to 0 immediately, and out_r SHALL clear to 0.
REQ-028 Reset mid-stream SHALL discard all in-flight coefficients; the first output after release has counter index 0.
REQ-029 in_ready SHALL read 1 during and after reset (pipeline empty).

Configuration
REQ-030 Macro TOMONT_FREEZE_EN defined: a 4th register stage SHALL add KYBER_Q when the stage-3 value is negative, so out_r lies in [0, q-1]; latency becomes 4 cycles.
REQ-031 Macro TOMONT_FREEZE_EN undefined: no 4th stage; latency is 3 cycles and the range follows REQ-018.
REQ-032 Handshake, stall and counter rules SHALL be identical in both builds.

Verification
REQ-033 Inputs 1, 0, -1, 3328, with out_ready held high -> out_r = -1044, 0, 1044, 1044 at cycles 3..6 (freeze build: 2285, 0, 1044, 1044 at cycles 4..7).
REQ-034 Stream 256 values 0..255 with out_ready=1 -> 256 outputs in order; out_last high only on the 256th; the next polynomial restarts at index 0.
REQ-035 Random out_ready (50%) and in_valid (50%) over 10k samples -> outputs match the golden model in order; out_r is stable through every stall.
REQ-036 out_ready low for 10 cycles with a full pipeline -> in_ready low, no change to out_r, then all outputs are drained correctly.
REQ-037 rst_n pulsed low asynchronously mid-polynomial with a full pipeline -> out_valid drops without waiting for a clock edge; the next output has out_last timing based on index 0.
REQ-038 Exhaustive in_a over -32768..32767 -> out_r ≡ in_a*65536 mod 3329 and within the range of the active build.
